// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment constants, hex table and index-width helper for the scan driver
package seven_seg_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int SEG_DP_BIT = 7;
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: load handshake, digit inputs and display pin outputs of the scan driver
interface seven_seg_scan_if #(parameter int NUM_DIGITS = 4);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_done;
  modport master (output load, digit_data, dp_mask, blank_mask, input seg_n, an_n, frame_done);
  modport slave  (input load, digit_data, dp_mask, blank_mask, output seg_n, an_n, frame_done);
endinterface

// File: rtl/seven_seg_hex_decode.sv
// seven_seg_hex_decode: hex nibble to active-low {dp,g..a}, with decimal point and blanking
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg_n
);
  assign seg_n = blank ? SEG_BLANK
                       : {HEX_SEG[nib][SEG_DP_BIT] & ~dp, HEX_SEG[nib][SEG_DP_BIT-1:0]};
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: double-buffered, time-multiplexed N-digit seven-segment driver (option: SEVEN_SEG_LZ_BLANK_EN)
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input logic clk,
  input logic rstn,
  seven_seg_scan_if.slave bus
);
  localparam int IW = idx_w(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = 4 * NUM_DIGITS;

  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic [DW-1:0]         stg_data_q, stg_data_d, disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0] stg_blank_q, stg_blank_d, disp_blank_q, disp_blank_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;
  logic                  tick, wrap, dark, upd_in, upd_stg;
  logic [3:0]            nibs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] eff_blank;
  logic [7:0]            dec_seg;

  // split the display register into per-digit nibbles for the scan mux
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) nibs[i] = disp_data_q[4*i +: 4];
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic zero_run;
  // leading-zero suppression: walk down from the top digit while nibble is 0 and dp clear; digit 0 always shown
  always_comb begin
    zero_run  = 1'b1;
    eff_blank = disp_blank_q;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run & (nibs[i] == 4'h0) & ~disp_dp_q[i];
      eff_blank[i] = eff_blank[i] | zero_run;
    end
  end
`else
  assign eff_blank = disp_blank_q;
`endif

  seven_seg_hex_decode u_dec (
    .nib   (nibs[idx_q]),
    .dp    (disp_dp_q[idx_q]),
    .blank (eff_blank[idx_q]),
    .seg_n (dec_seg)
  );

  // scan timing, staging/display buffering and next output values
  always_comb begin
    tick         = pre_q == PW'(SCAN_DIV - 1);
    wrap         = tick && (idx_q == IW'(NUM_DIGITS - 1));
    dark         = pre_q < PW'(BLANK_CYC);
    upd_in       = bus.load && wrap;
    upd_stg      = !bus.load && wrap && pend_q;
    pre_d        = tick ? '0 : pre_q + PW'(1);
    idx_d        = wrap ? '0 : tick ? idx_q + IW'(1) : idx_q;
    pend_d       = bus.load ? !wrap : wrap ? 1'b0 : pend_q;
    stg_data_d   = bus.load ? bus.digit_data : stg_data_q;
    stg_dp_d     = bus.load ? bus.dp_mask : stg_dp_q;
    stg_blank_d  = bus.load ? bus.blank_mask : stg_blank_q;
    disp_data_d  = upd_in ? bus.digit_data : upd_stg ? stg_data_q : disp_data_q;
    disp_dp_d    = upd_in ? bus.dp_mask : upd_stg ? stg_dp_q : disp_dp_q;
    disp_blank_d = upd_in ? bus.blank_mask : upd_stg ? stg_blank_q : disp_blank_q;
    seg_d        = dark ? SEG_BLANK : dec_seg;
    an_d         = dark ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    fd_d         = wrap;
  end

  // state and registered pin outputs; reset darkens the display immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      stg_data_q   <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      fd_q         <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      stg_data_q   <= stg_data_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fd_q         <= fd_d;
    end
  end

  assign bus.seg_n      = seg_q;
  assign bus.an_n       = an_q;
  assign bus.frame_done = fd_q;
endmodule
